// File: rtl/frame_input_buffer.sv
// rtl/frame_input_buffer.sv - ping-pong sample capture buffer feeding the FFT load sweep
module frame_input_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              loading_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              start_o,
    output logic              overrun_o,
    output logic [1:0]        full_cnt_o
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_LOAD
    } rd_state_e;

    // Both banks share one array; the bank select is the address MSB.
    logic [DATA_W-1:0] mem_q [0:2*DEPTH-1];

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic              overrun_q, overrun_d;
    logic              start_q;
    logic [1:0]        full_cnt_q;
    logic [ADDR_W:0]   rd_addr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_en;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        state_d   = state_q;
        wr_en     = sample_valid_i && !full_q[wr_bank_q];
        // Samples are judged against the pre-edge flag, so a bank released
        // this edge still rejects a sample aimed at it.
        overrun_d = overrun_q | (sample_valid_i && full_q[wr_bank_q]);

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == {ADDR_W{1'b1}}) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        case (state_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = R_REQ;
                end
            end
            R_REQ: begin
                if (loading_i) begin
                    state_d = R_LOAD;
                end
            end
            R_LOAD: begin
                if (!loading_i) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    state_d           = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_bank_q, wr_ptr_q}] <= sample_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= R_IDLE;
            wr_ptr_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= '0;
            overrun_q  <= 1'b0;
            start_q    <= 1'b0;
            full_cnt_q <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            overrun_q  <= overrun_d;
            // Held level: the address generator only samples start when idle.
            start_q    <= (state_d == R_REQ);
            full_cnt_q <= {1'b0, full_d[0]} + {1'b0, full_d[1]};
            rd_addr_q  <= {rd_bank_q, rd_addr_i};
            rd_data_q  <= mem_q[rd_addr_q];
        end
    end

    assign rd_data_o  = rd_data_q;
    assign start_o    = start_q;
    assign overrun_o  = overrun_q;
    assign full_cnt_o = full_cnt_q;

endmodule

// File: doc/frame_input_buffer.md
Name: frame_input_buffer

Overview:
- Ping-pong sample buffer directly upstream of the FFT address generator.
- Captures a continuous stream of real samples into two 1024-entry banks.
- When a bank is full, it requests an FFT run via start_o.
- Serves the address generator's LOAD-phase reads (read_address 0..1023) with fixed 2-cycle latency, while capture continues into the other bank.

Parameters:
- DATA_W, 16, sample width (two's complement, stored unmodified).
- ADDR_W, 10, bank address width; bank depth = 2^ADDR_W = 1024.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- sample_i  input  DATA_W  incoming sample.
- sample_valid_i  input  1  sample_i valid this cycle; no backpressure.
- rd_addr_i  input  ADDR_W  read address from the address generator's read_address_buffer output.
- loading_i  input  1  address generator's loading output; high during its LOAD state.
- rd_data_o  output  DATA_W  registered read data.
- start_o  output  1  FFT start request (level).
- overrun_o  output  1  sticky: a sample was dropped.
- full_cnt_o  output  2  number of banks currently full (0..2).

Behaviour:
- Reset: applies only on clk edge with rst_n=0.
  - wr_ptr=0, wr_bank=0, rd_bank=0, full[1:0]=0.
  - Read FSM returns to R_IDLE.
  - rd_data_o=0, start_o=0, overrun_o=0, full_cnt_o=0.
  - RAM contents are not cleared.
  - Reset mid-frame or mid-load discards all progress; the next sample lands at bank0 address 0.
- Write side, per cycle with sample_valid_i=1:
  - If full[wr_bank]=0: write bank[wr_bank][wr_ptr], then wr_ptr++.
  - If wr_ptr=2^ADDR_W-1 at the write: set full[wr_bank]=1, wr_ptr wraps to 0, wr_bank toggles.
  - If full[wr_bank]=1: sample dropped, wr_ptr unchanged, overrun_o<=1 until reset.
  - sample_valid_i=0: no change.
- Read FSM states:
  - R_IDLE: if full[rd_bank]=1, go to R_REQ.
  - R_REQ: start_o=1. Stays until loading_i=1, then go to R_LOAD with start_o<=0 on the same edge. start_o is held (not pulsed) because the address generator ignores start outside its idle state.
  - R_LOAD: while loading_i=1, stay. On loading_i=0: full[rd_bank]<=0, rd_bank toggles, go to R_IDLE.
- start_o is registered: high from the cycle after R_REQ entry until the cycle after loading_i is first seen high.
- Read path: rd_data_o = bank[rd_bank][rd_addr_i] with exactly 2 cycles latency (address registered into RAM, output registered). Valid regardless of FSM state.
  - rd_bank changes only on leaving R_LOAD, so the bank is stable for the whole LOAD sweep.
- Simultaneous events:
  - Write completing bank X on the same edge as release of bank Y: both take effect; full_cnt_o reflects both next cycle.
  - Write to a bank on the same edge it is released: the release happens that edge, but the sample is judged against the pre-edge flag and is dropped with overrun.
- full_cnt_o = full[0]+full[1], registered with the flags.
- Write and read banks never alias while full[rd_bank]=1; the write side only enters a bank whose flag is clear.

Test Plan:
- After reset, stream 1024 samples value=index (0..1023), loading_i=0 → full_cnt_o=1 one cycle after the last write; start_o rises next cycle and stays high.
- Continuing that run, raise loading_i, sweep rd_addr_i 0..1023 one per cycle → start_o drops one cycle after loading_i rises; rd_data_o equals the address presented 2 cycles earlier (0,1,...,1023).
- Continuing that run, drop loading_i → full_cnt_o returns to 0 and rd_bank=1. A second frame of 1024 values (1000+index) is read back from bank1 with the same 2-cycle latency.
- Stream 2048 samples back-to-back with loading_i held 0 → full_cnt_o=2, overrun_o=0. Sample 2049 → overrun_o=1 and stays 1. After release of bank0, the next sample is written at bank0 address 0.
- Complete bank1 on the same edge loading_i falls for bank0 → next cycle full_cnt_o=1, FSM in R_IDLE then R_REQ for bank1, start_o reasserts.
- Assert rst_n=0 for one cycle mid-load (rd_addr_i=500, start_o=0) → all outputs 0 next cycle. Capture restarts at bank0 address 0; the first start_o after 1024 further samples.
